// File: rtl/lcd_result_formatter.sv
// Formats a signed 16-bit result as sign + five decimal digits and streams the
// characters to the LCD controller over its write/ready handshake.
module lcd_result_formatter #(
   parameter logic [7:0] POS_CHAR       = 8'h2B,
   parameter bit         SUPPRESS_ZEROS = 1'b0
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        iStart,
   input  logic [15:0] iValue,
   input  logic        iReady,
   output logic        oWrite,
   output logic [7:0]  oData,
   output logic        oBusy,
   output logic        oDone
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_CONV, S_SEND, S_WAIT_LOW, S_WAIT_HIGH, S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic        sign_q, sign_d;
   logic [15:0] mag_q, mag_d;
   logic [13:0] divisor_q, divisor_d;
   logic [3:0]  digit_q, digit_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  char_q, char_d;
   logic        seen_q, seen_d;

   function automatic logic [13:0] next_divisor(input logic [13:0] d);
      case (d)
         14'd10000: return 14'd1000;
         14'd1000:  return 14'd100;
         14'd100:   return 14'd10;
         default:   return 14'd1;
      endcase
   endfunction

   // NOTE: async reset puts every register, including the character shown on
   // oData, back to a known value so a mid-stream reset drops oWrite at once.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         sign_q    <= 1'b0;
         mag_q     <= '0;
         divisor_q <= '0;
         digit_q   <= '0;
         idx_q     <= '0;
         char_q    <= '0;
         seen_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sign_q    <= sign_d;
         mag_q     <= mag_d;
         divisor_q <= divisor_d;
         digit_q   <= digit_d;
         idx_q     <= idx_d;
         char_q    <= char_d;
         seen_q    <= seen_d;
      end
   end

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      sign_d    = sign_q;
      mag_d     = mag_q;
      divisor_d = divisor_q;
      digit_d   = digit_q;
      idx_d     = idx_q;
      char_d    = char_q;
      seen_d    = seen_q;
      oWrite    = 1'b0;

      case (state_q)
         S_IDLE: if (iStart) begin
            sign_d  = iValue[15];
            mag_d   = iValue[15] ? (~iValue + 16'd1) : iValue;
            idx_d   = '0;
            digit_d = '0;
            seen_d  = 1'b0;
            state_d = S_LOAD;
         end
         S_LOAD: begin
            divisor_d = 14'd10000;
            digit_d   = '0;
            state_d   = S_CONV;
         end
         S_CONV: begin
            if (idx_q == 3'd0) begin
               char_d  = sign_q ? 8'h2D : POS_CHAR;
               state_d = S_SEND;
            end else if (mag_q >= {2'b00, divisor_q}) begin
               mag_d   = mag_q - {2'b00, divisor_q};
               digit_d = digit_q + 4'd1;
            end else begin
               // Blank only leading zeros; the units digit is always a numeral.
               if (SUPPRESS_ZEROS && idx_q < 3'd5 && digit_q == 4'd0 && !seen_q)
                  char_d = 8'h20;
               else
                  char_d = 8'h30 + {4'h0, digit_q};
               if (digit_q != 4'd0) seen_d = 1'b1;
               state_d = S_SEND;
            end
         end
         S_SEND: if (iReady) begin
            oWrite  = 1'b1;
            state_d = S_WAIT_LOW;
         end
         S_WAIT_LOW: if (!iReady) state_d = S_WAIT_HIGH;
         S_WAIT_HIGH: if (iReady) begin
            idx_d   = idx_q + 3'd1;
            // The sign character does not consume a decade.
            if (idx_q != 3'd0) divisor_d = next_divisor(divisor_q);
            digit_d = '0;
            state_d = (idx_q == 3'd5) ? S_DONE : S_CONV;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign oData = char_q;
   assign oBusy = (state_q != S_IDLE) && (state_q != S_DONE);
   assign oDone = (state_q == S_DONE);

endmodule

// File: tb/tb_lcd_result_formatter.sv
// Directed bench: both zero-suppression variants run in lockstep against an
// LCD-controller style ready handshake; expected strings are hand-computed.
module tb_lcd_result_formatter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start, ready;
   logic [15:0] value;
   logic        write0, busy0, done0, write1, busy1, done1;
   logic [7:0]  data0, data1;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] cap0 [6];
   logic [7:0] cap1 [6];
   int ncap;

   always #5 clk = ~clk;

   lcd_result_formatter #(.POS_CHAR(8'h2B), .SUPPRESS_ZEROS(1'b0)) u_dut (
      .Clock(clk), .Reset(rst), .iStart(start), .iValue(value), .iReady(ready),
      .oWrite(write0), .oData(data0), .oBusy(busy0), .oDone(done0));

   lcd_result_formatter #(.POS_CHAR(8'h2B), .SUPPRESS_ZEROS(1'b1)) u_dut_sz (
      .Clock(clk), .Reset(rst), .iStart(start), .iValue(value), .iReady(ready),
      .oWrite(write1), .oData(data1), .oBusy(busy1), .oDone(done1));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One formatting transaction. stall_after/reset_after/pulse_after are char
   // counts (-1 = unused); done_poke raises iStart in the oDone cycle.
   task automatic run(input string name, input logic [15:0] v,
                      input logic [47:0] exp0, input logic [47:0] exp1,
                      input int stall_after, input int reset_after,
                      input int pulse_after, input bit done_poke);
      int   phase, low_left, n_exp;
      bit   fin, bad_write, bad_data, pulsed;
      logic [7:0] held;
      phase = 0; low_left = 0; fin = 0; bad_write = 0; bad_data = 0; pulsed = 0;
      held = '0; ncap = 0;
      @(negedge clk);
      start = 1'b1; value = v; ready = 1'b1;
      for (int cyc = 0; cyc < 1000 && !fin; cyc++) begin
         @(negedge clk);
         start = 1'b0; value = 16'h5A5A;
         if (cyc == 0) check({name, "_busy"}, busy0, 1'b1);
         case (phase)
            0: begin
               if (done0) begin
                  fin = 1;
                  if (done_poke) begin start = 1'b1; value = 16'h7777; end
               end else if (write0) begin
                  if (ncap < 6) begin cap0[ncap] = data0; cap1[ncap] = data1; end
                  ncap++;
                  phase = 1;
                  if (ncap == reset_after) begin
                     #2 rst = 1'b1;
                     #1;
                     check({name, "_rst_write"}, write0, 1'b0);
                     check({name, "_rst_busy"}, busy0, 1'b0);
                     check({name, "_rst_data"}, data0, 8'h00);
                     @(negedge clk);
                     rst = 1'b0; ready = 1'b1;
                     fin = 1;
                  end
               end
            end
            1: begin
               if (write0) bad_write = 1;
               ready = 1'b0;
               low_left = (ncap == stall_after) ? 50 : 2;
               held = data0;
               phase = 2;
            end
            default: begin
               if (write0) bad_write = 1;
               if (data0 !== held) bad_data = 1;
               if (ncap == pulse_after && !pulsed) begin
                  start = 1'b1; value = 16'd100; pulsed = 1;
               end
               low_left--;
               if (low_left == 0) begin ready = 1'b1; phase = 0; end
            end
         endcase
      end
      check({name, "_end"}, fin, 1'b1);
      check({name, "_hs_write"}, bad_write, 1'b0);
      check({name, "_hs_data"}, bad_data, 1'b0);
      n_exp = (reset_after > 0) ? reset_after : 6;
      check({name, "_nchar"}, ncap, n_exp);
      for (int i = 0; i < n_exp && i < ncap && i < 6; i++) begin
         check($sformatf("%s_c%0d", name, i), cap0[i], exp0[47-8*i -: 8]);
         check($sformatf("%s_sz_c%0d", name, i), cap1[i], exp1[47-8*i -: 8]);
      end
      if (done_poke) begin
         @(negedge clk);
         start = 1'b0;
         check({name, "_poke_busy"}, busy0, 1'b0);
         check({name, "_poke_done"}, done0, 1'b0);
      end
   endtask

   initial begin
      bit extra;
      start = 1'b0; value = '0; ready = 1'b1;
      #1 rst = 1'b1;
      #1;
      check("reset_write", write0, 1'b0);
      check("reset_data", data0, 8'h00);
      check("reset_busy", busy0, 1'b0);
      check("reset_done", done0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      run("p1234", 16'd1234,   48'h2B3031323334, 48'h2B2031323334, -1, -1, -1, 0);
      run("n32768", 16'h8000,  48'h2D3332373638, 48'h2D3332373638, -1, -1, -1, 0);
      run("n1", 16'hFFFF,      48'h2D3030303031, 48'h2D2020202031, -1, -1, -1, 1);
      run("z0", 16'd0,         48'h2B3030303030, 48'h2B2020202030, -1, -1, -1, 0);
      run("v705", 16'd705,     48'h2B3030373035, 48'h2B2020373035, -1, -1, -1, 0);
      run("stall", 16'd20481,  48'h2B3230343831, 48'h2B3230343831,  2, -1, -1, 0);
      run("rst", 16'd31000,    48'h2B3331303030, 48'h2B3331303030, -1,  3, -1, 0);
      run("v9", 16'd9,         48'h2B3030303039, 48'h2B2020202039, -1, -1, -1, 0);
      run("busy42", 16'd42,    48'h2B3030303432, 48'h2B2020203432, -1, -1,  2, 0);

      extra = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy0 || done0) extra = 1;
      end
      check("busy42_no_restart", extra, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
